bus_reader: RTL and testbench

BUS_READER -- requirements
Module: bus_reader

---
 rtl/bus_reader.sv | 119 +++++++++++
 tb/tb_bus_reader.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bus_reader.sv
// rtl/bus_reader.sv - round-robin reader for a shared tristate bus: grant, settle, sample, hand off
module bus_reader #(
    parameter int N = 8,
    parameter int M = 4,
    parameter int W = $clog2(M)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [M-1:0] req,
    output logic [M-1:0] en,
    input  logic [N-1:0] bus,
    output logic [N-1:0] data_out,
    output logic [W-1:0] src,
    output logic         valid,
    input  logic         ready
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        SAMPLE,
        OUT
    } state_t;

    state_t         state_q, state_d;
    logic [M-1:0]   en_q, en_d;
    logic [N-1:0]   data_q, data_d;
    logic [W-1:0]   src_q, src_d;
    logic [W-1:0]   last_q, last_d;
    logic [W-1:0]   grant_q, grant_d;
    logic           valid_q, valid_d;

    logic           win_found;
    logic [W-1:0]   win_idx;

    // First requester strictly after the last winner, wrapping around.
    always_comb begin
        int cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= M; k++) begin
            cand = (int'(last_q) + k) % M;
            if (!win_found && req[cand[W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        data_d  = data_q;
        src_d   = src_q;
        last_d  = last_q;
        grant_d = grant_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                en_d = '0;
                if (win_found) begin
                    en_d[win_idx] = 1'b1;
                    grant_d       = win_idx;
                    last_d        = win_idx;
                    state_d       = GRANT;
                end
            end
            GRANT: begin
                state_d = SAMPLE;
            end
            SAMPLE: begin
                data_d  = bus;
                src_d   = grant_q;
                en_d    = '0;
                valid_d = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                // Returning through IDLE gives the bus one undriven turnaround cycle.
                if (ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                en_d    = '0;
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            en_q    <= '0;
            data_q  <= '0;
            src_q   <= '0;
            last_q  <= W'(M - 1);
            grant_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            data_q  <= data_d;
            src_q   <= src_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
        end
    end

    assign en       = en_q;
    assign data_out = data_q;
    assign src      = src_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_bus_reader.sv
// tb/tb_bus_reader.sv - directed vector table plus stall and latency sequences for bus_reader
module tb_bus_reader;
    localparam int N = 8;
    localparam int M = 4;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [M-1:0] req = '0;
    logic [M-1:0] en;
    logic [N-1:0] bus = '0;
    logic [N-1:0] data_out;
    logic [W-1:0] src;
    logic         valid;
    logic         ready = 1'b1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_reader #(.N(N), .M(M), .W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .en       (en),
        .bus      (bus),
        .data_out (data_out),
        .src      (src),
        .valid    (valid),
        .ready    (ready)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [7:0] bus;
        logic       ready;
        logic [3:0] en;
        logic       valid;
        logic [7:0] data;
        logic [1:0] src;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [3:0] rq, input logic [7:0] b,
                                input logic rd, input logic [3:0] e, input logic v,
                                input logic [7:0] d, input logic [1:0] s);
        vec_t x;
        x.rst = r; x.req = rq; x.bus = b; x.ready = rd;
        x.en = e; x.valid = v; x.data = d; x.src = s;
        vecs.push_back(x);
    endfunction

    task automatic apply_vec(input vec_t x, input int idx);
        rst   = x.rst;
        req   = x.req;
        bus   = x.bus;
        ready = x.ready;
        @(posedge clk);
        #1;
        checks++;
        if (en !== x.en || valid !== x.valid || data_out !== x.data || src !== x.src) begin
            failures++;
            $display("FAIL vec%0d: got en=%b valid=%b data=%h src=%0d, want en=%b valid=%b data=%h src=%0d",
                     idx, en, valid, data_out, src, x.en, x.valid, x.data, x.src);
        end
    endtask

    task automatic check_outs(input string name, input logic [3:0] e, input logic v,
                              input logic [7:0] d, input logic [1:0] s);
        checks++;
        if (en !== e || valid !== v || data_out !== d || src !== s) begin
            failures++;
            $display("FAIL %s: got en=%b valid=%b data=%h src=%0d, want en=%b valid=%b data=%h src=%0d",
                     name, en, valid, data_out, src, e, v, d, s);
        end
    endtask

    logic [3:0] prev_en = '0;
    always @(negedge clk) begin
        if (!$onehot0(en)) begin
            checks++;
            failures++;
            $display("FAIL onehot_en: en=%b, want at most one bit set", en);
        end
        if (prev_en != 4'b0 && en != 4'b0 && en != prev_en) begin
            checks++;
            failures++;
            $display("FAIL en_turnaround: en=%b right after en=%b, want a zero cycle between", en, prev_en);
        end
        prev_en = en;
    end

    initial begin
        logic [7:0] pd;
        logic [1:0] ps;
        logic [1:0] g;
        logic [7:0] w;
        logic [3:0] oh;
        logic [3:0] rq;
        int n;

        // Single requester on driver 2, word A5.
        add(1, 4'b0000, 8'h00, 1, 4'b0000, 0, 8'h00, 0);
        add(0, 4'b0100, 8'hA5, 1, 4'b0100, 0, 8'h00, 0);
        add(0, 4'b0100, 8'hA5, 1, 4'b0100, 0, 8'h00, 0);
        add(0, 4'b0100, 8'hA5, 1, 4'b0000, 1, 8'hA5, 2);
        add(0, 4'b0000, 8'hA5, 1, 4'b0000, 0, 8'hA5, 2);
        add(0, 4'b0000, 8'hA5, 1, 4'b0000, 0, 8'hA5, 2);

        // All requesters held: rotation 0,1,2,3,0 with one word every 4 cycles.
        add(1, 4'b0000, 8'h00, 1, 4'b0000, 0, 8'h00, 0);
        pd = 8'h00;
        ps = 2'd0;
        for (int i = 0; i < 5; i++) begin
            g  = 2'(i % 4);
            w  = 8'h10 + 8'(g);
            oh = 4'b0001 << g;
            rq = (i == 4) ? 4'b0000 : 4'b1111;
            add(0, 4'b1111, 8'h00, 1, oh,      0, pd, ps);
            add(0, 4'b1111, w,     1, oh,      0, pd, ps);
            add(0, rq,      w,     1, 4'b0000, 1, w,  g);
            add(0, rq,      w,     1, 4'b0000, 0, w,  g);
            pd = w;
            ps = g;
        end

        // Driver 1 granted, request withdrawn during GRANT; transfer still completes.
        add(0, 4'b0010, 8'h00, 1, 4'b0010, 0, 8'h10, 0);
        add(0, 4'b0000, 8'h5A, 1, 4'b0010, 0, 8'h10, 0);
        add(0, 4'b0000, 8'h5A, 1, 4'b0000, 1, 8'h5A, 1);
        add(0, 4'b0000, 8'h5A, 1, 4'b0000, 0, 8'h5A, 1);

        // Reset during SAMPLE aborts; afterwards driver 3 is granted.
        add(0, 4'b0100, 8'h00, 1, 4'b0100, 0, 8'h5A, 1);
        add(0, 4'b0100, 8'h00, 1, 4'b0100, 0, 8'h5A, 1);
        add(1, 4'b0100, 8'h00, 1, 4'b0000, 0, 8'h00, 0);
        add(0, 4'b1000, 8'h77, 1, 4'b1000, 0, 8'h00, 0);
        add(0, 4'b1000, 8'h77, 1, 4'b1000, 0, 8'h00, 0);
        add(0, 4'b0000, 8'h77, 1, 4'b0000, 1, 8'h77, 3);
        add(0, 4'b0000, 8'h77, 1, 4'b0000, 0, 8'h77, 3);

        foreach (vecs[i]) apply_vec(vecs[i], i);

        // Stall: capture on driver 0 with a bounded wait, then hold off ready.
        rst   = 1'b0;
        req   = 4'b0001;
        bus   = 8'h3C;
        ready = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!valid && n < 10);
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL latency: valid after %0d cycles, want 3", n);
        end
        check_outs("capture_3c", 4'b0000, 1, 8'h3C, 0);

        req = 4'b0000;
        bus = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_outs("stall_hold", 4'b0000, 1, 8'h3C, 0);
        end

        ready = 1'b1;
        @(posedge clk);
        #1;
        check_outs("stall_release", 4'b0000, 0, 8'h3C, 0);
        @(posedge clk);
        #1;
        check_outs("idle_after_release", 4'b0000, 0, 8'h3C, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
